// File: rtl/text_ram_pkg.sv
// text_ram_pkg: shared widths and types for the text RAM arbiter and its read-tag pipeline.
package text_ram_pkg;

  localparam int unsigned TEXT_ADDR_W = 12;
  localparam int unsigned TEXT_DATA_W = 32;

  // Which client a RAM read result belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_PAR  = 2'd2
  } owner_t;

  // Starvation guard states.
  typedef enum logic {
    S_NORMAL = 1'b0,
    S_FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/text_ram_arbiter_if.sv
// text_ram_arbiter_if: video and parser request/return buses plus the single text RAM port.
// The slave modport is the arbiter's view; the master modport is the clients' and RAM's view.
interface text_ram_arbiter_if #(
  parameter int unsigned ADDR_W = text_ram_pkg::TEXT_ADDR_W,
  parameter int unsigned DATA_W = text_ram_pkg::TEXT_DATA_W
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              par_req;
  logic              par_we;
  logic [ADDR_W-1:0] par_addr;
  logic [DATA_W-1:0] par_wdata;
  logic              par_gnt;
  logic              par_rvalid;
  logic [DATA_W-1:0] par_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr, par_req, par_we, par_addr, par_wdata, ram_rdata,
    output vid_gnt, vid_rvalid, vid_rdata, par_gnt, par_rvalid, par_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, par_req, par_we, par_addr, par_wdata, ram_rdata,
    input  vid_gnt, vid_rvalid, vid_rdata, par_gnt, par_rvalid, par_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/text_ram_rd_tag_pipe.sv
// text_ram_rd_tag_pipe: RD_LAT-deep shift register of read owner tags, aligned with the RAM
// read latency so the tail tag names the owner of the data currently on ram_rdata.
module text_ram_rd_tag_pipe
  import text_ram_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t push_tag,
  output owner_t tail_tag
);

  owner_t stage_q [RD_LAT];

  // Shift tags one stage per cycle; reset drops every outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= OWN_NONE;
      end
    end else begin
      stage_q[0] <= push_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail_tag = stage_q[RD_LAT-1];

endmodule

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares the single-port text RAM between video fetch (fixed priority)
// and the VT100 parser datapath, routing each read result back to its issuer.
// Optional starvation guard compiled in with `define TEXT_RAM_ARB_STARVE_GUARD_EN.
module text_ram_arbiter
  import text_ram_pkg::*;
#(
  parameter int unsigned ADDR_W   = TEXT_ADDR_W,
  parameter int unsigned DATA_W   = TEXT_DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst,
  text_ram_arbiter_if.slave bus
);

  logic              vid_gnt;
  logic              par_gnt;
  logic              guard_fire;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  owner_t            push_tag;
  owner_t            tail_tag;

`ifdef TEXT_RAM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] WaitLimit = 4'(MAX_WAIT);

  arb_state_t state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign guard_fire = (state_q == S_FORCE);

  // Count denied parser cycles and arm a forced parser slot once the limit is hit.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_NORMAL: begin
        if (par_gnt) begin
          wait_cnt_d = 4'd0;
        end else if (bus.par_req) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
        if (wait_cnt_d == WaitLimit) begin
          state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        // Either the forced grant was taken or the parser withdrew; both restart the count.
        state_d    = S_NORMAL;
        wait_cnt_d = 4'd0;
      end
      default: begin
        state_d    = S_NORMAL;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Guard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_NORMAL;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // Strict video priority: the parser only gets slots video leaves idle.
  assign guard_fire = 1'b0;
`endif

  // Fixed-priority grant: forced parser slot, then video, then parser.
  always_comb begin
    vid_gnt = 1'b0;
    par_gnt = 1'b0;
    if (!rst) begin
      if (guard_fire && bus.par_req) begin
        par_gnt = 1'b1;
      end else if (bus.vid_req) begin
        vid_gnt = 1'b1;
      end else if (bus.par_req) begin
        par_gnt = 1'b1;
      end
    end
  end

  // RAM command mux; address and write data hold their last value while idle.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (vid_gnt) begin
      addr_d = bus.vid_addr;
    end else if (par_gnt) begin
      addr_d  = bus.par_addr;
      wdata_d = bus.par_wdata;
    end
  end

  // Hold register for the RAM address/data bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Tag every cycle: granted reads name their owner, writes and idle cycles are OWN_NONE.
  always_comb begin
    push_tag = OWN_NONE;
    if (vid_gnt) begin
      push_tag = OWN_VID;
    end else if (par_gnt && !bus.par_we) begin
      push_tag = OWN_PAR;
    end
  end

  text_ram_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .push_tag (push_tag),
    .tail_tag (tail_tag)
  );

  assign bus.vid_gnt    = vid_gnt;
  assign bus.par_gnt    = par_gnt;
  assign bus.ram_en     = vid_gnt | par_gnt;
  assign bus.ram_we     = par_gnt & bus.par_we;
  assign bus.ram_addr   = addr_d;
  assign bus.ram_wdata  = wdata_d;
  assign bus.vid_rvalid = (tail_tag == OWN_VID);
  assign bus.par_rvalid = (tail_tag == OWN_PAR);
  assign bus.vid_rdata  = bus.ram_rdata;
  assign bus.par_rdata  = bus.ram_rdata;

endmodule

// File: doc/text_ram_arbiter.md
# text_ram_arbiter

Shares the single-port text RAM between the video fetch path and the VT100 parser's text datapath. Video reads get fixed priority so raster deadlines hold, and parser reads and writes fill the idle slots. An optional starvation guard gives the parser a slot after a bounded wait. Each read result goes back to the port that issued it, using an owner-tag pipeline matched to the RAM read latency.

## Interface
Parameters:
- ADDR_W, 12, text RAM cell address width
- DATA_W, 32, cell width (character plus attributes)
- RD_LAT, 1, RAM read latency in clock edges (1..4)
- MAX_WAIT, 4, cycles the parser may be denied before the starvation guard forces a grant (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- vid_req  in  1  video read request; held with vid_addr until granted
- vid_addr  in  ADDR_W  video read address
- vid_gnt  out  1  video request accepted this cycle
- vid_rvalid  out  1  vid_rdata valid
- vid_rdata  out  DATA_W  video read data
- par_req  in  1  parser request; held with par_we/par_addr/par_wdata until granted
- par_we  in  1  1 = write, 0 = read
- par_addr  in  ADDR_W  parser address
- par_wdata  in  DATA_W  parser write data
- par_gnt  out  1  parser request accepted this cycle
- par_rvalid  out  1  par_rdata valid
- par_rdata  out  DATA_W  parser read data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data

## Operation
- Acceptance:
  - A transfer happens on a port in any cycle where req and gnt are both high.
  - Requesters must not derive req from gnt.
- Grant logic (combinational from req, the guard state and rst):
  - rst high: both gnt low and ram_en low.
  - Otherwise, if the guard is firing and par_req is high: par_gnt=1 and vid_gnt=0.
  - Otherwise, if vid_req is high: vid_gnt=1.
  - Otherwise, if par_req is high: par_gnt=1.
  - At most one gnt is high in any cycle.
- RAM command:
  - ram_en = vid_gnt | par_gnt, driven in the grant cycle.
  - ram_addr and ram_wdata come from the granted port.
  - ram_we = par_gnt & par_we; video never writes.
  - When ram_en is low, ram_we=0 and addr/wdata hold their last value.
- Read return:
  - Every granted read pushes an owner tag (OWN_VID/OWN_PAR) into an RD_LAT-deep shift register. Writes and idle cycles push OWN_NONE.
  - At the tail, OWN_VID asserts vid_rvalid and OWN_PAR asserts par_rvalid, each for exactly one cycle.
  - vid_rdata and par_rdata both carry ram_rdata and are qualified only by the matching rvalid.
- Starvation guard state machine (STARVE_GUARD_EN only):
  - States: S_NORMAL, S_FORCE.
  - wait_cnt (4 bits) increments in every cycle where par_req=1 and par_gnt=0, and clears whenever par_gnt=1.
  - S_NORMAL→S_FORCE: at the edge where wait_cnt becomes MAX_WAIT.
  - S_FORCE→S_NORMAL: at the edge of the forced parser grant; wait_cnt clears at the same edge.
  - If par_req drops while in S_FORCE, return to S_NORMAL and clear wait_cnt.
- Back-to-back: one access per cycle. Alternating ownership and mixed read/write streams need no bubbles.

## Timing
- Grant latency: 0 cycles (same cycle as req when the port wins).
- Read latency: a read accepted at edge E returns with rvalid high during the cycle after edge E+RD_LAT−1, i.e. RD_LAT cycles after the grant cycle.
- Write takes effect at the grant edge; a parser read of the same address granted the next cycle returns the new data.
- Worst-case parser wait with the guard: MAX_WAIT denied cycles, then a grant on the next cycle.
- Reset values (edge with rst=1):
  - Tag pipeline cleared to OWN_NONE, so vid_rvalid=0 and par_rvalid=0.
  - State S_NORMAL, wait_cnt=0.
  - ram_addr=0, ram_wdata=0.
- Reset mid-operation: outstanding reads are dropped and no rvalid fires for them.
- Simultaneous requests with the guard idle: video wins and the parser waits.

## Configuration
- TEXT_RAM_ARB_STARVE_GUARD_EN defined: starvation guard, wait_cnt and S_FORCE are compiled in as above.
- Not defined: strict video priority. wait_cnt and the state machine are absent, and the parser can be denied indefinitely while vid_req stays high.

## Structure
- Shared package text_ram_pkg holds:
  - TEXT_ADDR_W and TEXT_DATA_W constants;
  - the owner_t enum {OWN_NONE, OWN_VID, OWN_PAR};
  - the arb_state_t enum {S_NORMAL, S_FORCE}.
- One sub-module, text_ram_rd_tag_pipe: parameterised RD_LAT-deep owner_t shift register with synchronous clear.
- Grant mux, RAM command mux and guard logic live in text_ram_arbiter.

## Test plan
- Video-only read stream, RD_LAT=1:
  - Stimulus: vid_req high, addresses 0..7 on consecutive cycles.
  - Required: vid_gnt high every cycle; vid_rvalid high on 8 consecutive cycles starting one cycle later, carrying the data at 0..7 in order; par_rvalid stays 0.
- Parser write then read:
  - Stimulus: write 0x0000_0141 to address 0x050, then read 0x050.
  - Required: ram_we=1 in the write grant cycle; par_rvalid with par_rdata=0x0000_0141 one cycle after the read grant.
- Contention:
  - Stimulus: both req high with the guard compiled out.
  - Required: vid_gnt every cycle and par_gnt never for 100 cycles.
- Starvation guard, MAX_WAIT=4:
  - Stimulus: both req held high.
  - Required: pattern of 4 video grants, 1 parser grant, repeating; wait_cnt never exceeds 4.
- Tag routing, RD_LAT=3:
  - Stimulus: interleaved V,P,V reads.
  - Required: rvalid sequence vid, par, vid, arriving 3 cycles after each grant.
- Reset mid-flight, RD_LAT=3:
  - Stimulus: assert rst for 1 cycle with two reads outstanding.
  - Required: no rvalid for those reads; both gnt low during rst; normal operation the cycle after.
